// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared arbiter types
package rr_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/pri.sv
// rtl/pri.sv - fixed priority selector, one-hot result, zero when no request
module pri #(
    parameter int W        = 8,
    parameter bit FROM_LSB = 1'b1
) (
    input  logic [W-1:0] i_req,
    output logic [W-1:0] o_gnt
);

    logic found;

    always_comb begin
        o_gnt = '0;
        found = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (FROM_LSB) begin
                if (i_req[i] && !found) begin
                    o_gnt[i] = 1'b1;
                    found    = 1'b1;
                end
            end else begin
                if (i_req[W-1-i] && !found) begin
                    o_gnt[W-1-i] = 1'b1;
                    found        = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rr_arb.sv
// rtl/rr_arb.sv - round-robin arbiter with optional grant lock over multi-beat transfers
module rr_arb
    import rr_arb_pkg::*;
#(
    parameter int W    = 8,
    parameter bit LOCK = 1'b1
) (
    input  logic                              clk,
    input  logic                              arst_n,
    input  logic [W-1:0]                      i_req,
    input  logic                              i_ack,
    input  logic                              i_last,
    output logic [W-1:0]                      o_gnt,
    output logic                              o_gnt_vld,
    output logic [((W > 1) ? $clog2(W) : 1)-1:0] o_gnt_idx
);

    localparam int IW = (W > 1) ? $clog2(W) : 1;

    arb_state_e    state_q;
    logic [W-1:0]  gnt_q;
    logic          vld_q;
    logic [IW-1:0] idx_q;
    logic [W-1:0]  mask_q;
    logic [W-1:0]  mask_d;
    logic [W-1:0]  gnt_masked;
    logic [W-1:0]  gnt_plain;
    logic [W-1:0]  pick;
    logic          complete;

    function automatic logic [IW-1:0] to_idx(input logic [W-1:0] oh);
        logic [IW-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) begin
            if (oh[i]) r = r | IW'(i);
        end
        return r;
    endfunction

    assign complete = (state_q == ST_GRANT) && i_ack && (i_last || !LOCK);

    // The post-completion mask feeds arbitration in the same cycle so back-to-back grants have no bubble.
    always_comb begin
        mask_d = mask_q;
        if (complete) begin
            for (int j = 0; j < W; j++) begin
                mask_d[j] = (j > int'(idx_q));
            end
        end
    end

    pri #(.W(W), .FROM_LSB(1'b1)) u_pri_masked (
        .i_req (i_req & mask_d),
        .o_gnt (gnt_masked)
    );

    pri #(.W(W), .FROM_LSB(1'b1)) u_pri_plain (
        .i_req (i_req),
        .o_gnt (gnt_plain)
    );

    assign pick = (|(i_req & mask_d)) ? gnt_masked : gnt_plain;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            vld_q   <= 1'b0;
            idx_q   <= '0;
            mask_q  <= '1;
        end else begin
            mask_q <= mask_d;
            case (state_q)
                ST_IDLE: begin
                    if (|i_req) begin
                        state_q <= ST_GRANT;
                        gnt_q   <= pick;
                        vld_q   <= 1'b1;
                        idx_q   <= to_idx(pick);
                    end
                end
                ST_GRANT: begin
                    if (complete) begin
                        if (|i_req) begin
                            gnt_q <= pick;
                            vld_q <= 1'b1;
                            idx_q <= to_idx(pick);
                        end else begin
                            state_q <= ST_IDLE;
                            gnt_q   <= '0;
                            vld_q   <= 1'b0;
                            idx_q   <= '0;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_gnt     = gnt_q;
    assign o_gnt_vld = vld_q;
    assign o_gnt_idx = idx_q;

endmodule
